// File: rtl/piccolo_uart_pkg.sv
// Shared definitions for the Piccolo host-link UART: FSM encodings, clog2 and bit-period helper.
// The bit-period helper is also used by the RXD receiver so both ends round the divider the same way.
package piccolo_uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result++;
            v = v >> 1;
        end
        return result;
    endfunction

    // Clock cycles per bit, rounded to nearest.
    function automatic int baud_div(input int clock_freq, input int baudrate);
        return (clock_freq + baudrate / 2) / baudrate;
    endfunction

endpackage

// File: rtl/piccolo_uart_if.sv
// Byte sink handshake into the TXD transmitter (Avalon-ST style valid/ready).
interface piccolo_uart_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/piccolo_uart_fifo.sv
// Single-clock first-word-fall-through FIFO; q shows the head whenever empty is low.
// Latency: a write is visible on q/usedw the cycle after it is accepted.
// Backpressure: writes while full and reads while empty are ignored.
module piccolo_uart_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wrreq,
    input  logic [WIDTH-1:0]      data,
    input  logic                  rdreq,
    output logic [WIDTH-1:0]      q,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   usedw
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [DEPTH_LOG2:0] wptr;
    logic [DEPTH_LOG2:0] rptr;
    logic                do_wr;
    logic                do_rd;

    // Pointers carry one extra bit so full and empty are distinguishable.
    assign usedw = wptr - rptr;
    assign empty = (wptr == rptr);
    assign full  = usedw[DEPTH_LOG2];
    assign q     = mem[rptr[DEPTH_LOG2-1:0]];
    assign do_wr = wrreq & ~full;
    assign do_rd = rdreq & ~empty;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_wr) wptr <= wptr + (DEPTH_LOG2 + 1)'(1);
            if (do_rd) rptr <= rptr + (DEPTH_LOG2 + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wptr[DEPTH_LOG2-1:0]] <= data;
    end

endmodule

// File: rtl/piccolo_uart_tx.sv
// Host-link 8N1 serial transmitter: buffers bytes in a FIFO and shifts them out LSB-first on txd.
// Latency: a byte accepted into an empty FIFO while idle drops txd 2 clk later.
// Backpressure: in_ready = FIFO not full (and low in reset); frames run back-to-back while data is queued.
module piccolo_uart_tx
    import piccolo_uart_pkg::*;
#(
    parameter int CLOCK_FREQ      = 50000000,
    parameter int BAUDRATE        = 115200,
    parameter int FIFO_DEPTH_LOG2 = 4,
    parameter int STOP_BITS       = 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    piccolo_uart_if.slave            sink,
    output logic                     txd,
    output logic                     busy,
    output logic [FIFO_DEPTH_LOG2:0] fifo_level
);
    localparam int DIV   = baud_div(CLOCK_FREQ, BAUDRATE);
    localparam int CNT_W = clog2(DIV);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(DIV - 1);
    localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

    if (DIV < 2) begin : g_div_check
        $error("piccolo_uart_tx: bit period below 2 clk cycles");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_stop_check
        $error("piccolo_uart_tx: STOP_BITS must be 1 or 2");
    end

    tx_state_t        state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift_reg;
    logic             accept_en;
    logic [7:0]       fifo_q;
    logic             fifo_empty;
    logic             fifo_full;
    logic             bit_done;
    logic             stop_done;
    logic             pop;

    assign sink.in_ready = accept_en & ~fifo_full;
    assign bit_done      = (baud_cnt == BAUD_LAST);
    assign stop_done     = (state == ST_STOP) & bit_done & (bit_cnt == STOP_LAST);
    assign pop           = ~fifo_empty & ((state == ST_IDLE) | stop_done);
    assign busy          = (state != ST_IDLE) | (fifo_level != '0);

    piccolo_uart_fifo #(
        .WIDTH      (8),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wrreq   (sink.in_valid & sink.in_ready),
        .data    (sink.in_data),
        .rdreq   (pop),
        .q       (fifo_q),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .usedw   (fifo_level)
    );

    // txd is registered from the current state, so the line trails the FSM by one clk throughout.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            txd       <= 1'b1;
            accept_en <= 1'b0;
        end else begin
            accept_en <= 1'b1;
            case (state)
                ST_IDLE: begin
                    txd      <= 1'b1;
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                    if (pop) begin
                        shift_reg <= fifo_q;
                        state     <= ST_START;
                    end
                end
                ST_START: begin
                    txd <= 1'b0;
                    if (bit_done) begin
                        baud_cnt <= '0;
                        state    <= ST_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    txd <= shift_reg[0];
                    if (bit_done) begin
                        baud_cnt  <= '0;
                        shift_reg <= {1'b0, shift_reg[7:1]};
                        bit_cnt   <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= ST_STOP;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    txd <= 1'b1;
                    if (bit_done) begin
                        baud_cnt <= '0;
                        if (bit_cnt == STOP_LAST) begin
                            bit_cnt <= '0;
                            if (pop) begin
                                shift_reg <= fifo_q;
                                state     <= ST_START;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_piccolo_uart_tx.sv
// Scoreboard bench: pushes queue expected bytes, a line monitor decodes txd frames and compares.
module tb_piccolo_uart_tx;

    localparam int DIV_A = 434;  // (50000000 + 57600) / 115200
    localparam int DIV_B = 52;   // (500000 + 4800) / 9600

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n_a;
    logic       reset_n_b;
    logic       txd_a, busy_a, txd_b, busy_b;
    logic [4:0] level_a, level_b;

    piccolo_uart_if ifa ();
    piccolo_uart_if ifb ();

    piccolo_uart_tx dut_a (
        .clk        (clk),
        .reset_n    (reset_n_a),
        .sink       (ifa.slave),
        .txd        (txd_a),
        .busy       (busy_a),
        .fifo_level (level_a)
    );

    piccolo_uart_tx #(
        .CLOCK_FREQ      (500000),
        .BAUDRATE        (9600),
        .FIFO_DEPTH_LOG2 (4),
        .STOP_BITS       (2)
    ) dut_b (
        .clk        (clk),
        .reset_n    (reset_n_b),
        .sink       (ifb.slave),
        .txd        (txd_b),
        .busy       (busy_b),
        .fifo_level (level_b)
    );

    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    int         skip_frames = 0;
    logic       use_b = 1'b0;
    int         cur_div = DIV_A;
    int         cur_stop = 1;
    logic [7:0] exp_q[$];

    logic       txd_sel, busy_sel, ready_sel;
    logic [4:0] level_sel;
    assign txd_sel   = use_b ? txd_b : txd_a;
    assign busy_sel  = use_b ? busy_b : busy_a;
    assign ready_sel = use_b ? ifb.in_ready : ifa.in_ready;
    assign level_sel = use_b ? level_b : level_a;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Caller sits at a negedge; returns at the negedge after the accepting posedge.
    task automatic push(input logic [7:0] b);
        bit done;
        done = 0;
        if (use_b) begin ifb.in_data = b; ifb.in_valid = 1'b1; end
        else       begin ifa.in_data = b; ifa.in_valid = 1'b1; end
        for (int i = 0; i < 20000; i++) begin
            if (ready_sel === 1'b1) begin
                done = 1;
                break;
            end
            @(negedge clk);
        end
        if (done) begin
            exp_q.push_back(b);
            @(negedge clk);
        end else begin
            n_checks++;
            n_errors++;
            $display("FAIL push_timeout: in_ready stayed 0 for byte %02h, expected 1", b);
        end
        ifa.in_valid = 1'b0;
        ifb.in_valid = 1'b0;
    endtask

    // Cycle-exact line and busy waveform for one frame, starting right after push returns.
    task automatic check_wave(input string name, input logic [7:0] b, input int d, input int s);
        int   nbits, k, bad_txd, bad_busy;
        logic e;
        nbits    = 9 + s;
        bad_txd  = 0;
        bad_busy = 0;
        @(negedge clk);
        check({name, "_txd_before_start"}, txd_sel, 1);
        for (int c = 0; c < nbits * d; c++) begin
            @(negedge clk);
            k = c / d;
            e = (k == 0) ? 1'b0 : (k <= 8) ? b[k-1] : 1'b1;
            if (txd_sel !== e) bad_txd++;
            if (busy_sel !== (c != nbits * d - 1)) bad_busy++;
        end
        check({name, "_txd_bad_cycles"}, bad_txd, 0);
        check({name, "_busy_bad_cycles"}, bad_busy, 0);
    endtask

    task automatic wait_idle(input int max_cycles, output int t_end);
        t_end = -1;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (!busy_sel) begin
                t_end = cyc;
                break;
            end
        end
        if (t_end < 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL wait_idle: busy still 1 after %0d cycles, expected 0", max_cycles);
        end
    endtask

    // Line monitor: samples each bit mid-period and scores the decoded byte.
    initial begin : monitor
        logic       prev, ok_start, ok_stop;
        logic [7:0] b;
        int         d, s;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (prev && txd_sel === 1'b0) begin
                d = cur_div;
                s = cur_stop;
                repeat (d / 2) @(negedge clk);
                ok_start = txd_sel;
                for (int i = 0; i < 8; i++) begin
                    repeat (d) @(negedge clk);
                    b[i] = txd_sel;
                end
                ok_stop = 1'b1;
                for (int j = 0; j < s; j++) begin
                    repeat (d) @(negedge clk);
                    ok_stop &= txd_sel;
                end
                if (skip_frames > 0) begin
                    skip_frames--;
                end else begin
                    check("mon_start_bit", ok_start, 0);
                    check("mon_stop_bits", ok_stop, 1);
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL mon_unexpected_frame: got byte %02h, expected no frame", b);
                    end else begin
                        check("mon_byte", b, exp_q.pop_front());
                    end
                end
            end
            prev = txd_sel;
        end
    end

    initial begin : stim
        int         bad_txd, bad_busy, bad_rdy, bad_lvl, t0, t_end;
        logic [7:0] t4_bytes [17];
        t4_bytes = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                     8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
        reset_n_a    = 1'b0;
        reset_n_b    = 1'b0;
        ifa.in_valid = 1'b0;
        ifa.in_data  = 8'h00;
        ifb.in_valid = 1'b0;
        ifb.in_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_txd", txd_a, 1);
        check("rst_in_ready", ifa.in_ready, 0);
        check("rst_busy", busy_a, 0);
        check("rst_level", level_a, 0);
        reset_n_a = 1'b1;
        reset_n_b = 1'b1;
        repeat (2) @(negedge clk);

        // Quiet line after reset.
        bad_txd = 0; bad_busy = 0; bad_rdy = 0; bad_lvl = 0;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            if (txd_a !== 1'b1) bad_txd++;
            if (busy_a !== 1'b0) bad_busy++;
            if (ifa.in_ready !== 1'b1) bad_rdy++;
            if (level_a !== 5'd0) bad_lvl++;
        end
        check("idle_txd_bad_cycles", bad_txd, 0);
        check("idle_busy_bad_cycles", bad_busy, 0);
        check("idle_ready_bad_cycles", bad_rdy, 0);
        check("idle_level_bad_cycles", bad_lvl, 0);

        // Single frame, exact timing.
        push(8'h55);
        check_wave("f55", 8'h55, DIV_A, 1);
        repeat (20) @(negedge clk);

        // Three back-to-back frames with no idle gap.
        push(8'hA5);
        t0 = cyc;
        push(8'h3C);
        push(8'hFF);
        wait_idle(40000, t_end);
        check("b2b_busy_fall_cycle", t_end, t0 + 1 + 30 * DIV_A);
        repeat (20) @(negedge clk);

        // Reset mid-DATA abandons the frame and flushes the FIFO.
        skip_frames = 1;
        push(8'h00);
        exp_q.delete();
        push(8'h11);
        exp_q.delete();
        repeat (4 * DIV_A + DIV_A / 2) @(negedge clk);
        check("pre_rst_txd_low", txd_a, 0);
        check("pre_rst_level", level_a, 1);
        reset_n_a = 1'b0;
        #1;
        check("mid_rst_txd", txd_a, 1);
        check("mid_rst_in_ready", ifa.in_ready, 0);
        check("mid_rst_level", level_a, 0);
        repeat (2) @(negedge clk);
        reset_n_a = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_in_ready", ifa.in_ready, 1);
        bad_txd = 0; bad_busy = 0;
        for (int i = 0; i < 12 * DIV_A; i++) begin
            @(negedge clk);
            if (txd_a !== 1'b1) bad_txd++;
            if (busy_a !== 1'b0) bad_busy++;
        end
        check("post_rst_txd_bad_cycles", bad_txd, 0);
        check("post_rst_busy_bad_cycles", bad_busy, 0);

        // Second instance: slower line, two stop bits.
        use_b    = 1'b1;
        cur_div  = DIV_B;
        cur_stop = 2;
        repeat (5) @(negedge clk);
        push(8'h81);
        check_wave("f81_2stop", 8'h81, DIV_B, 2);
        repeat (20) @(negedge clk);

        // Unpaced burst of 17: one in the shifter, 16 queued.
        for (int i = 0; i < 17; i++) push(t4_bytes[i]);
        check("burst_in_ready_full", ifb.in_ready, 0);
        check("burst_level_full", level_b, 16);
        wait_idle(17 * 11 * DIV_B + 500, t_end);
        check("burst_all_frames_seen", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
